// File: rtl/esi_cosim_loopback_fifo.sv
// Multi-channel buffered loopback between an ESI cosim endpoint's receive and
// send ports: each channel is a small FIFO with a fixed output transform.
module esi_cosim_loopback_fifo #(
    parameter int NUM_CH         = 1,
    parameter int TYPE_SIZE_BITS = 192,
    parameter int DEPTH          = 4,
    parameter int MODE           = 0,
    parameter int CNT_W          = 32
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_CH-1:0]                DataOutValid,
    output logic [NUM_CH-1:0]                DataOutReady,
    input  logic [NUM_CH*TYPE_SIZE_BITS-1:0] DataOut,
    output logic [NUM_CH-1:0]                DataInValid,
    input  logic [NUM_CH-1:0]                DataInReady,
    output logic [NUM_CH*TYPE_SIZE_BITS-1:0] DataIn,
    output logic [NUM_CH*CNT_W-1:0]          RecvCount,
    output logic [NUM_CH*CNT_W-1:0]          SentCount
);
    localparam int W     = TYPE_SIZE_BITS;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    // Storage keeps the raw message; the transform is applied only at the output.
    function automatic logic [W-1:0] transform(input logic [W-1:0] x);
        case (MODE)
            1:       transform = ~x;
            2:       transform = x + W'(1);
            default: transform = x;
        endcase
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [W-1:0]     mem_q [DEPTH];
        logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
        logic [OCC_W-1:0] occ_q, occ_d;
        logic [CNT_W-1:0] recv_cnt_q, recv_cnt_d;
        logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
        logic             push;
        logic             pop;

        // Handshake qualifiers depend only on state and reset, never on the peer's valid.
        assign DataOutReady[i] = rstn && (occ_q != OCC_FULL);
        assign DataInValid[i]  = rstn && (occ_q != '0);
        assign push            = DataOutValid[i] && DataOutReady[i];
        assign pop             = DataInValid[i] && DataInReady[i];

        assign DataIn[i*W +: W]             = transform(mem_q[rd_ptr_q]);
        assign RecvCount[i*CNT_W +: CNT_W]  = recv_cnt_q;
        assign SentCount[i*CNT_W +: CNT_W]  = sent_cnt_q;

        always_comb begin
            wr_ptr_d   = wr_ptr_q;
            rd_ptr_d   = rd_ptr_q;
            occ_d      = occ_q;
            recv_cnt_d = recv_cnt_q;
            sent_cnt_d = sent_cnt_q;
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                recv_cnt_d = recv_cnt_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                sent_cnt_d = sent_cnt_q + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rstn) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                occ_q      <= '0;
                recv_cnt_q <= '0;
                sent_cnt_q <= '0;
            end else begin
                wr_ptr_q   <= wr_ptr_d;
                rd_ptr_q   <= rd_ptr_d;
                occ_q      <= occ_d;
                recv_cnt_q <= recv_cnt_d;
                sent_cnt_q <= sent_cnt_d;
            end
        end

        // Contents are left stale on reset; the zeroed occupancy hides them.
        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_ptr_q] <= DataOut[i*W +: W];
            end
        end
    end

endmodule

// File: tb/tb_esi_cosim_loopback_fifo.sv
// Randomized and directed bench for esi_cosim_loopback_fifo: three instances
// (identity, invert, increment) share stimulus and are checked against a queue model.
module tb_esi_cosim_loopback_fifo;
    localparam int NUM_CH = 2;
    localparam int W      = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;
    localparam int NMODE  = 3;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic [NUM_CH-1:0]       out_valid = '0;
    logic [NUM_CH-1:0]       in_ready = '0;
    logic [NUM_CH*W-1:0]     data_out = '0;
    logic [NUM_CH-1:0]       out_ready [NMODE];
    logic [NUM_CH-1:0]       in_valid [NMODE];
    logic [NUM_CH*W-1:0]     data_in [NMODE];
    logic [NUM_CH*CNT_W-1:0] recv_count [NMODE];
    logic [NUM_CH*CNT_W-1:0] sent_count [NMODE];

    int assert_count = 0;
    int fail_count = 0;

    logic [W-1:0] model_q [NUM_CH][$];
    int           recv_model [NUM_CH];
    int           sent_model [NUM_CH];

    always #5 clk = ~clk;

    for (genvar m = 0; m < NMODE; m++) begin : g_dut
        esi_cosim_loopback_fifo #(
            .NUM_CH(NUM_CH), .TYPE_SIZE_BITS(W), .DEPTH(DEPTH), .MODE(m), .CNT_W(CNT_W)
        ) u_dut (
            .clk(clk),
            .rstn(rstn),
            .DataOutValid(out_valid),
            .DataOutReady(out_ready[m]),
            .DataOut(data_out),
            .DataInValid(in_valid[m]),
            .DataInReady(in_ready),
            .DataIn(data_in[m]),
            .RecvCount(recv_count[m]),
            .SentCount(sent_count[m])
        );
    end

    function automatic logic [W-1:0] expect_xform(input int mode, input logic [W-1:0] x);
        if (mode == 1) return ~x;
        if (mode == 2) return x + 8'd1;
        return x;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check outputs against the
    // model, then advance the model by the handshakes the next rising edge will see.
    task automatic applyStimulus(input logic rst_val, input logic [NUM_CH-1:0] vin,
                                 input logic [NUM_CH*W-1:0] din, input logic [NUM_CH-1:0] rin);
        logic [NUM_CH-1:0] exp_ready;
        logic [NUM_CH-1:0] exp_valid;
        @(negedge clk);
        rstn      = rst_val;
        out_valid = vin;
        data_out  = din;
        in_ready  = rin;
        #1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            exp_ready[ch] = rst_val && (model_q[ch].size() != DEPTH);
            exp_valid[ch] = rst_val && (model_q[ch].size() != 0);
        end
        for (int m = 0; m < NMODE; m++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                checkOutput($sformatf("m%0d ch%0d ready", m, ch), 32'(out_ready[m][ch]), 32'(exp_ready[ch]));
                checkOutput($sformatf("m%0d ch%0d valid", m, ch), 32'(in_valid[m][ch]), 32'(exp_valid[ch]));
                if (exp_valid[ch])
                    checkOutput($sformatf("m%0d ch%0d data", m, ch), 32'(data_in[m][ch*W +: W]),
                                32'(expect_xform(m, model_q[ch][0])));
                checkOutput($sformatf("m%0d ch%0d recv", m, ch), 32'(recv_count[m][ch*CNT_W +: CNT_W]),
                            32'(recv_model[ch] % (1 << CNT_W)));
                checkOutput($sformatf("m%0d ch%0d sent", m, ch), 32'(sent_count[m][ch*CNT_W +: CNT_W]),
                            32'(sent_model[ch] % (1 << CNT_W)));
            end
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (!rst_val) begin
                model_q[ch].delete();
                recv_model[ch] = 0;
                sent_model[ch] = 0;
            end else begin
                if (exp_valid[ch] && rin[ch]) begin
                    void'(model_q[ch].pop_front());
                    sent_model[ch]++;
                end
                if (vin[ch] && exp_ready[ch]) begin
                    model_q[ch].push_back(din[ch*W +: W]);
                    recv_model[ch]++;
                end
            end
        end
    endtask

    initial begin
        int pct_in;
        int pct_out;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            recv_model[ch] = 0;
            sent_model[ch] = 0;
        end

        // Reset state
        applyStimulus(1'b0, 2'b00, 16'h0000, 2'b00);
        applyStimulus(1'b0, 2'b00, 16'h0000, 2'b00);

        // Five messages straight through channel 0
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 2'b01, 16'(i), 2'b11);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 16'h0000, 2'b11);
        checkOutput("five recv", 32'(recv_count[0][3:0]), 32'd5);
        checkOutput("five sent", 32'(sent_count[0][3:0]), 32'd5);

        // Fill to full with the consumer stalled, then drain
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'b01, 16'(8'h10 + i), 2'b00);
        checkOutput("full ready low", 32'(out_ready[0][0]), 32'd0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'b00, 16'h0000, 2'b01);

        // Transform boundaries: 0xFF and 0x7F, then 0xA5
        applyStimulus(1'b0, 2'b00, 16'h0000, 2'b00);
        applyStimulus(1'b1, 2'b11, 16'h7FFF, 2'b00);
        applyStimulus(1'b1, 2'b00, 16'h0000, 2'b00);
        checkOutput("inc ff", 32'(data_in[2][7:0]), 32'h00);
        checkOutput("inc 7f", 32'(data_in[2][15:8]), 32'h80);
        checkOutput("ident 7fff", 32'(data_in[0]), 32'h7FFF);
        applyStimulus(1'b0, 2'b00, 16'h0000, 2'b00);
        applyStimulus(1'b1, 2'b11, 16'hA5A5, 2'b00);
        applyStimulus(1'b1, 2'b00, 16'h0000, 2'b00);
        checkOutput("inv a5", 32'(data_in[1]), 32'h5A5A);

        // Channel 1 stalled while channel 0 streams
        applyStimulus(1'b0, 2'b00, 16'h0000, 2'b00);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2'b11, 16'({8'(8'h40 + i), 8'(8'h20 + i)}), 2'b01);
        checkOutput("stream ch0 ready", 32'(out_ready[0][0]), 32'd1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'b00, 16'h0000, 2'b11);

        // Reset with three messages buffered, then idle
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b11, 16'(16'h3131 + i), 2'b00);
        applyStimulus(1'b0, 2'b00, 16'h0000, 2'b11);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b00, 16'h0000, 2'b11);

        // Seventeen messages wrap the 4-bit counters to 1
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 2'b01, 16'(i * 3), 2'b01);
        applyStimulus(1'b1, 2'b00, 16'h0000, 2'b01);
        applyStimulus(1'b1, 2'b00, 16'h0000, 2'b01);
        checkOutput("wrap recv", 32'(recv_count[0][3:0]), 32'd1);
        checkOutput("wrap sent", 32'(sent_count[0][3:0]), 32'd1);

        // Random traffic with shifting bias on both sides
        for (int i = 0; i < 10000; i++) begin
            logic [NUM_CH-1:0] vin;
            logic [NUM_CH-1:0] rin;
            if (i % 500 == 0) begin
                pct_in  = $urandom_range(10, 100);
                pct_out = $urandom_range(10, 100);
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                vin[ch] = ($urandom_range(0, 99) < pct_in);
                rin[ch] = ($urandom_range(0, 99) < pct_out);
            end
            applyStimulus(($urandom_range(0, 999) != 0), vin, 16'($urandom), rin);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
